// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue controller and the ALU it feeds:
//   DW / AW      - datapath width and register-address width
//   state_e      - issue FSM state encoding (IDLE -> EXEC -> WB)
//   OP_*         - 4-bit opcode constants understood by the ALU
package alu_pkg;

  localparam int DW = 16;
  localparam int AW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b0101;

endpackage

// File: rtl/reg_file_8x16.sv
// reg_file_8x16
// 2**AW x DW register file, one synchronous write port, three asynchronous
// read ports, asynchronous active-low reset to zero. Register 0 is an
// ordinary register.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   we_i, waddr_i, wdata_i     write port (takes effect at the rising edge)
//   ra_i/ra_data_o             read port A (R operand)
//   rb_i/rb_data_o             read port B (S operand)
//   rc_i/rc_data_o             read port C (observation)
module reg_file_8x16 #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] ra_i,
  input  logic [AW-1:0] rb_i,
  input  logic [AW-1:0] rc_i,
  output logic [DW-1:0] ra_data_o,
  output logic [DW-1:0] rb_data_o,
  output logic [DW-1:0] rc_data_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // No write-first bypass: reads always see the stored contents.
  assign ra_data_o = mem_q[ra_i];
  assign rb_data_o = mem_q[rb_i];
  assign rc_data_o = mem_q[rc_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issues one register-to-register command at a time to an external
// combinational ALU: latch operands (accept), let the ALU settle (EXEC),
// write the result and flags back (WB).
// Ports:
//   clk, reset                        clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_op, cmd_dst, cmd_rs, cmd_ss   opcode and register indices
//   ld_en, ld_addr, ld_data           direct register preload (IDLE only)
//   alu_R, alu_S, alu_op              registered operands/opcode to the ALU
//   alu_Y, alu_N, alu_Z, alu_C        ALU result and flags
//   status                            {N,Z,C} of the last completed op
//   done                              one-cycle pulse during writeback
//   rd_addr, rd_data                  combinational register observation
module alu_issue_ctrl #(
  parameter int DW = alu_pkg::DW,
  parameter int AW = alu_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_ss,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_R,
  output logic [DW-1:0] alu_S,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_Y,
  input  logic          alu_N,
  input  logic          alu_Z,
  input  logic          alu_C,
  output logic [2:0]    status,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  import alu_pkg::*;

  state_e        state_q;
  logic [DW-1:0] r_q, s_q, y_q;
  logic [3:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [2:0]    flags_q, status_q;
  logic          done_q;

  logic [DW-1:0] rs_data, ss_data;
  logic          we_d;
  logic [AW-1:0] waddr_d;
  logic [DW-1:0] wdata_d;
  logic          accept;

  // Preload wins over a command offered in the same IDLE cycle.
  assign cmd_ready = (state_q == ST_IDLE) && !ld_en;
  assign accept    = cmd_valid && cmd_ready;

  // The two write sources are mutually exclusive by state.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = ld_addr;
    wdata_d = ld_data;
    if (state_q == ST_IDLE && ld_en) begin
      we_d = 1'b1;
    end else if (state_q == ST_WB) begin
      we_d    = 1'b1;
      waddr_d = dst_q;
      wdata_d = y_q;
    end
  end

  reg_file_8x16 #(.DW(DW), .AW(AW)) u_rf (
    .clk_i     (clk),
    .rst_ni    (reset),
    .we_i      (we_d),
    .waddr_i   (waddr_d),
    .wdata_i   (wdata_d),
    .ra_i      (cmd_rs),
    .rb_i      (cmd_ss),
    .rc_i      (rd_addr),
    .ra_data_o (rs_data),
    .rb_data_o (ss_data),
    .rc_data_o (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      s_q      <= '0;
      y_q      <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      flags_q  <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            // Operands are copied here so a later write to rs/ss (including
            // the writeback of this very command) cannot disturb them.
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            r_q     <= rs_data;
            s_q     <= ss_data;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          y_q     <= alu_Y;
          flags_q <= {alu_N, alu_Z, alu_C};
          done_q  <= 1'b1;
          state_q <= ST_WB;
        end
        ST_WB: begin
          // Register write happens via the write port on this same edge.
          status_q <= flags_q;
          done_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_R  = r_q;
  assign alu_S  = s_q;
  assign alu_op = op_q;
  assign status = status_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Self-checking bench: an ALU stub closes the loop around the DUT and a
// register-array reference model predicts register contents, status and
// handshake timing for directed scenarios and a randomized command mix.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_rs, cmd_ss;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_R, alu_S;
  logic [3:0]  alu_op;
  logic [15:0] alu_Y;
  logic        alu_N, alu_Z, alu_C;
  logic [2:0]  status;
  logic        done;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] ref_reg [8];
  logic [2:0]  ref_status;
  logic [15:0] last_r, last_s;
  logic [3:0]  last_op;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_rs    (cmd_rs),
    .cmd_ss    (cmd_ss),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_R     (alu_R),
    .alu_S     (alu_S),
    .alu_op    (alu_op),
    .alu_Y     (alu_Y),
    .alu_N     (alu_N),
    .alu_Z     (alu_Z),
    .alu_C     (alu_C),
    .status    (status),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // ALU stub: returns {N,Z,C,Y}; C is carry-out for add, borrow for sub.
  function automatic logic [18:0] alu_stub(input logic [3:0] op,
                                           input logic [15:0] r,
                                           input logic [15:0] s);
    logic [16:0] t;
    case (op)
      4'd0:    t = {1'b0, r} + {1'b0, s};
      4'd1:    t = {1'b0, r} - {1'b0, s};
      4'd2:    t = {1'b0, r & s};
      4'd3:    t = {1'b0, r | s};
      4'd4:    t = {1'b0, r ^ s};
      default: t = {1'b0, r};
    endcase
    return {t[15], (t[15:0] == 16'h0000), t[16], t[15:0]};
  endfunction

  always_comb {alu_N, alu_Z, alu_C, alu_Y} = alu_stub(alu_op, alu_R, alu_S);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_reg[i] = 16'h0000;
    ref_status = 3'b000;
    last_r  = 16'h0000;
    last_s  = 16'h0000;
    last_op = 4'h0;
  endtask

  task automatic peek(input logic [2:0] a, input logic [15:0] exp, input string tag);
    rd_addr = a;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_reg[a] = d;
    peek(a, d, "preload");
  endtask

  // Issue one command starting in IDLE; returns one cycle after writeback.
  // hold keeps cmd_valid asserted afterwards; ld_exec attempts a preload
  // of the destination during EXEC, which must be ignored.
  task automatic issue(input logic [3:0] op, input logic [2:0] dst,
                       input logic [2:0] rs, input logic [2:0] ss,
                       input bit hold, input bit ld_exec);
    logic [15:0] r, s, y;
    logic [2:0]  fl;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_rs = rs; cmd_ss = ss;
    rd_addr = dst;
    #1;
    check("ready_idle", 32'(cmd_ready), 32'd1);
    r = ref_reg[rs];
    s = ref_reg[ss];
    {fl, y} = alu_stub(op, r, s);
    @(posedge clk); #1;               // EXEC
    if (!hold) cmd_valid = 1'b0;
    check("exec_done", 32'(done), 32'd0);
    check("exec_ready", 32'(cmd_ready), 32'd0);
    check("exec_R", 32'(alu_R), 32'(r));
    check("exec_S", 32'(alu_S), 32'(s));
    check("exec_op", 32'(alu_op), 32'(op));
    if (ld_exec) begin
      ld_en = 1'b1; ld_addr = dst; ld_data = ~ref_reg[dst] ^ 16'h5A5A;
    end
    @(posedge clk); #1;               // WB
    ld_en = 1'b0;
    check("wb_done", 32'(done), 32'd1);
    check("wb_ready", 32'(cmd_ready), 32'd0);
    check("wb_old_rd", 32'(rd_data), 32'(ref_reg[dst]));
    check("wb_status_old", 32'(status), 32'(ref_status));
    check("wb_R_hold", 32'(alu_R), 32'(r));
    @(posedge clk); #1;               // back in IDLE
    ref_reg[dst] = y;
    ref_status = fl;
    last_r = r; last_s = s; last_op = op;
    check("post_done", 32'(done), 32'd0);
    check("post_rd", 32'(rd_data), 32'(y));
    check("post_status", 32'(status), 32'(fl));
    check("post_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("idle_done", 32'(done), 32'd0);
      check("idle_R", 32'(alu_R), 32'(last_r));
      check("idle_S", 32'(alu_S), 32'(last_s));
      check("idle_op", 32'(alu_op), 32'(last_op));
      check("idle_status", 32'(status), 32'(ref_status));
    end
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_dst = 3'd0;
    cmd_rs = 3'd0; cmd_ss = 3'd0; ld_en = 1'b0; ld_addr = 3'd0;
    ld_data = 16'h0000; rd_addr = 3'd0;
    model_reset();
    #12;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_R", 32'(alu_R), 32'd0);
    check("rst_S", 32'(alu_S), 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 8; i++) peek(3'(i), 16'h0000, "rst_reg");

    @(posedge clk); #1;
    reset = 1'b1;
    // First accept at the first edge after reset release: 0 - 0.
    issue(4'd1, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0);
    check("first_status", 32'(status), 32'b010);

    // Add scenario with hand-computed result.
    preload(3'd1, 16'hAAFF);
    preload(3'd2, 16'h1234);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0);
    peek(3'd3, 16'hBD33, "add_reg3");
    check("add_status", 32'(status), 32'b100);

    // In-place: R1 = R1 + R1 with 0x8000 overflows to zero with carry.
    preload(3'd1, 16'h8000);
    issue(4'd0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
    peek(3'd1, 16'h0000, "inplace_reg1");
    check("inplace_status", 32'(status), 32'b011);

    // Back-to-back with cmd_valid held; the second reads the first's result.
    preload(3'd6, 16'h0F0F);
    issue(4'd1, 3'd4, 3'd3, 3'd6, 1'b1, 1'b0);
    issue(4'd4, 3'd7, 3'd4, 3'd3, 1'b0, 1'b0);

    // Preload and command together in IDLE: preload wins, command waits.
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_dst = 3'd0; cmd_rs = 3'd2; cmd_ss = 3'd5;
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'hF00D;
    #1;
    check("ldcmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_reg[5] = 16'hF00D;
    check("ldcmd_noaccept_op", 32'(alu_op), 32'(last_op));
    check("ldcmd_done", 32'(done), 32'd0);
    peek(3'd5, 16'hF00D, "ldcmd_write");
    issue(4'd2, 3'd0, 3'd2, 3'd5, 1'b0, 1'b0);

    // Preload attempted during EXEC is ignored.
    issue(4'd3, 3'd2, 3'd6, 3'd1, 1'b0, 1'b1);
    idle(3);

    // Reset in EXEC aborts the operation.
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_dst = 3'd7; cmd_rs = 3'd2; cmd_ss = 3'd6;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check("abort_R", 32'(alu_R), 32'd0);
    check("abort_S", 32'(alu_S), 32'd0);
    check("abort_op", 32'(alu_op), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    peek(3'd7, 16'h0000, "abort_reg7");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_nodone", 32'(done), 32'd0);
      check("abort_status", 32'(status), 32'd0);
      peek(3'd7, 16'h0000, "abort_reg7_later");
    end

    // Randomized mix of preloads, commands and idle cycles.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(3, 0))
        0: preload(3'($urandom_range(7, 0)), 16'($urandom));
        1, 2: issue(4'($urandom_range(5, 0)), 3'($urandom_range(7, 0)),
                    3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                    1'b0, 1'($urandom_range(1, 0)));
        default: idle(1);
      endcase
    end
    for (int i = 0; i < 8; i++) peek(3'(i), ref_reg[i], "final_reg");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
